// File: rtl/uart_cmd_seq.sv
// UART command sequencer: assembles 3-byte commands from the receiver and
// queues response bytes (one in flight, one pending) to the transmitter.
module uart_cmd_seq #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        resp_req,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent,
    output logic        frame_err,
    output logic        resp_drop
);

    typedef enum logic [1:0] {B0, B1, B2, HOLD} rx_state_t;
    typedef enum logic {TIDLE, TBUSY} tx_state_t;

    rx_state_t   rx_state;
    tx_state_t   tx_state;
    logic [15:0] tmo_cnt;
    logic        tmo_hit;
    logic        pend_vld;
    logic [7:0]  pend_data;

    // NOTE: combinational on purpose so the receiver sees the consume in the
    // same cycle the byte is captured; a registered version would double-read.
    assign clr_rx_rdy = rx_rdy && (rx_state != HOLD);
    assign tmo_hit    = (tmo_cnt == TIMEOUT_CYC - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= B0;
            cmd       <= 24'h0;
            cmd_rdy   <= 1'b0;
            tmo_cnt   <= 16'h0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle, so each assignment
            // below lasts exactly one clock.
            frame_err <= 1'b0;
            case (rx_state)
                B0: begin
                    tmo_cnt <= 16'h0;
                    if (rx_rdy) begin
                        cmd[23:16] <= rx_data;
                        rx_state   <= B1;
                    end
                end
                B1, B2: begin
                    // A byte arriving on the timeout cycle wins over the timeout.
                    if (rx_rdy) begin
                        tmo_cnt <= 16'h0;
                        if (rx_state == B1) begin
                            cmd[15:8] <= rx_data;
                            rx_state  <= B2;
                        end else begin
                            cmd[7:0] <= rx_data;
                            cmd_rdy  <= 1'b1;
                            rx_state <= HOLD;
                        end
                    end else if (tmo_hit) begin
                        frame_err <= 1'b1;
                        tmo_cnt   <= 16'h0;
                        rx_state  <= B0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    tmo_cnt <= 16'h0;
                    if (clr_cmd_rdy) begin
                        cmd_rdy  <= 1'b0;
                        rx_state <= B0;
                    end
                end
                default: rx_state <= B0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TIDLE;
            tx_data   <= 8'h0;
            pend_vld  <= 1'b0;
            pend_data <= 8'h0;
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            resp_drop <= 1'b0;
        end else begin
            trmt      <= 1'b0;
            resp_sent <= 1'b0;
            resp_drop <= 1'b0;
            case (tx_state)
                TIDLE: begin
                    if (resp_req) begin
                        tx_data  <= resp;
                        trmt     <= 1'b1;
                        tx_state <= TBUSY;
                    end
                end
                TBUSY: begin
                    if (tx_done) begin
                        resp_sent <= 1'b1;
                        if (pend_vld) begin
                            // Launching the pending byte frees the buffer for
                            // a request arriving in this same cycle.
                            tx_data  <= pend_data;
                            trmt     <= 1'b1;
                            pend_vld <= resp_req;
                            if (resp_req) pend_data <= resp;
                        end else if (resp_req) begin
                            tx_data <= resp;
                            trmt    <= 1'b1;
                        end else begin
                            tx_state <= TIDLE;
                        end
                    end else if (resp_req) begin
                        if (!pend_vld) begin
                            pend_data <= resp;
                            pend_vld  <= 1'b1;
                        end else begin
                            resp_drop <= 1'b1;
                        end
                    end
                end
                default: tx_state <= TIDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_seq.sv
// Scoreboard bench for uart_cmd_seq: stimulus queues expected commands and
// transmitted bytes; a negedge monitor pops and compares as the DUT presents them.
module tb_uart_cmd_seq;

    localparam logic [15:0] TMO = 16'd16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        clr_rx_rdy;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        resp_req = 1'b0;
    logic [7:0]  resp = 8'h0;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done = 1'b0;
    logic        resp_sent;
    logic        frame_err;
    logic        resp_drop;

    uart_cmd_seq #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_rdy      (rx_rdy),
        .rx_data     (rx_data),
        .clr_rx_rdy  (clr_rx_rdy),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp_req    (resp_req),
        .resp        (resp),
        .trmt        (trmt),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err),
        .resp_drop   (resp_drop)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [23:0] exp_cmd_q[$];
    logic [7:0]  exp_tx_q[$];
    int          n_clr = 0, n_trmt = 0, n_sent = 0, n_drop = 0, n_ferr = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name, input string msg);
        n_vec++;
        n_miss++;
        $display("FAIL %s: %s", name, msg);
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic        cmd_rdy_q, trmt_q, sent_q, drop_q, ferr_q, cur_valid;
        logic [23:0] cur_cmd;
        logic [7:0]  exp_b;
        cmd_rdy_q = 0; trmt_q = 0; sent_q = 0; drop_q = 0; ferr_q = 0;
        cur_valid = 0; cur_cmd = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cmd_rdy_q = 0; trmt_q = 0; sent_q = 0; drop_q = 0; ferr_q = 0;
                cur_valid = 0;
            end else begin
                if (cmd_rdy) begin
                    if (!cmd_rdy_q) begin
                        if (exp_cmd_q.size() == 0) begin
                            fail("cmd_unexpected", $sformatf("got %h, expected no command", cmd));
                            cur_valid = 0;
                        end else begin
                            cur_cmd   = exp_cmd_q.pop_front();
                            cur_valid = 1;
                        end
                    end
                    if (cur_valid) check("cmd_value", cmd, cur_cmd);
                end else begin
                    cur_valid = 0;
                end
                if (trmt) begin
                    n_trmt++;
                    check("trmt_width", trmt_q, 0);
                    if (exp_tx_q.size() == 0) begin
                        fail("tx_unexpected", $sformatf("got %h, expected no byte", tx_data));
                    end else begin
                        exp_b = exp_tx_q.pop_front();
                        check("tx_data", tx_data, exp_b);
                    end
                end
                if (clr_rx_rdy) n_clr++;
                if (resp_sent) begin n_sent++; check("resp_sent_width", sent_q, 0); end
                if (resp_drop) begin n_drop++; check("resp_drop_width", drop_q, 0); end
                if (frame_err) begin n_ferr++; check("frame_err_width", ferr_q, 0); end
                cmd_rdy_q = cmd_rdy;
                trmt_q    = trmt;
                sent_q    = resp_sent;
                drop_q    = resp_drop;
                ferr_q    = frame_err;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok, done;
        done    = 0;
        rx_data = b;
        rx_rdy  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ok = clr_rx_rdy;
            @(posedge clk);
            #1;
            if (ok) begin
                done = 1;
                break;
            end
        end
        rx_rdy = 1'b0;
        if (!done) fail("rx_consume", $sformatf("byte %h not consumed within 100 cycles", b));
    endtask

    task automatic send_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_cmd_q.push_back({b0, b1, b2});
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        check("cmd_rdy_after_3rd", cmd_rdy, 1);
    endtask

    task automatic ack_cmd();
        clr_cmd_rdy = 1'b1;
        cycles(1);
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_cleared", cmd_rdy, 0);
    endtask

    task automatic req(input logic [7:0] b);
        resp_req = 1'b1;
        resp     = b;
        cycles(1);
        resp_req = 1'b0;
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        cycles(1);
        tx_done = 1'b0;
    endtask

    initial begin
        int edges;

        // Reset state, held across several clock edges
        cycles(3);
        check("rst_cmd", cmd, 24'h0);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_tx_data", tx_data, 8'h0);
        check("rst_trmt", trmt, 0);
        check("rst_pulses", {clr_rx_rdy, frame_err, resp_sent, resp_drop}, 4'h0);
        rst_n = 1'b1;
        cycles(2);

        // Basic command assembly
        send_cmd(8'hA5, 8'h12, 8'h34);
        check("clr_count_cmd1", n_clr, 3);

        // Byte arriving while a command is held stays pending until ack
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        cycles(5);
        check("hold_no_clr", n_clr, 3);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        check("clr_in_hold_ack", clr_rx_rdy, 0);
        @(posedge clk);
        #1;
        clr_cmd_rdy = 1'b0;
        check("cmd_rdy_after_ack", cmd_rdy, 0);
        @(negedge clk);
        check("clr_in_b0", clr_rx_rdy, 1);
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        check("opcode_77", cmd[23:16], 8'h77);
        exp_cmd_q.push_back(24'h770102);
        send_byte(8'h01);
        send_byte(8'h02);
        check("cmd_rdy_cmd2", cmd_rdy, 1);
        ack_cmd();
        check("clr_count_cmd2", n_clr, 6);

        // Inter-byte timeout on a partial command
        send_byte(8'hC1);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (frame_err) break;
        end
        check("timeout_edges", edges, 16);
        check("timeout_cmd_rdy", cmd_rdy, 0);
        cycles(2);
        check("ferr_count_1", n_ferr, 1);
        send_cmd(8'hD1, 8'hD2, 8'hD3);
        ack_cmd();

        // Byte on the timeout cycle takes priority
        exp_cmd_q.push_back(24'hE1E2E3);
        send_byte(8'hE1);
        cycles(15);
        send_byte(8'hE2);
        send_byte(8'hE3);
        check("cmd_rdy_boundary", cmd_rdy, 1);
        cycles(2);
        check("ferr_count_boundary", n_ferr, 1);
        ack_cmd();
        check("clr_count_rx", n_clr, 13);

        // Response path: send, pend, drop
        exp_tx_q.push_back(8'h0A);
        exp_tx_q.push_back(8'h0B);
        req(8'h0A);
        req(8'h0B);
        req(8'h0C);
        cycles(2);
        check("drop_count_1", n_drop, 1);
        check("trmt_count_1", n_trmt, 1);
        done_pulse();
        cycles(2);
        check("trmt_count_2", n_trmt, 2);
        check("sent_count_1", n_sent, 1);
        done_pulse();
        cycles(2);
        check("sent_count_2", n_sent, 2);
        check("trmt_count_2b", n_trmt, 2);

        // tx_done while idle is ignored
        done_pulse();
        cycles(2);
        check("idle_done_ignored", n_sent, 2);

        // tx_done with resp_req while a byte is pending: no drop
        exp_tx_q.push_back(8'h11);
        exp_tx_q.push_back(8'h22);
        exp_tx_q.push_back(8'h33);
        req(8'h11);
        req(8'h22);
        cycles(2);
        resp_req = 1'b1;
        resp     = 8'h33;
        tx_done  = 1'b1;
        cycles(1);
        resp_req = 1'b0;
        tx_done  = 1'b0;
        cycles(2);
        check("simul_no_drop", n_drop, 1);
        check("simul_trmt", n_trmt, 4);
        check("simul_sent", n_sent, 3);
        done_pulse();
        cycles(2);
        check("simul_trmt_2", n_trmt, 5);
        done_pulse();
        cycles(2);
        check("simul_sent_3", n_sent, 5);
        check("simul_trmt_3", n_trmt, 5);

        // Asynchronous reset mid-command and mid-transmit
        send_byte(8'hF1);
        send_byte(8'hF2);
        exp_tx_q.push_back(8'h55);
        req(8'h55);
        req(8'h56);
        cycles(1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_cmd", cmd, 24'h0);
        check("arst_cmd_rdy", cmd_rdy, 0);
        check("arst_tx_data", tx_data, 8'h0);
        check("arst_pulses", {trmt, clr_rx_rdy, frame_err, resp_sent, resp_drop}, 5'h0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        done_pulse();
        cycles(2);
        check("post_rst_idle", n_sent, 5);
        exp_tx_q.push_back(8'h66);
        req(8'h66);
        cycles(2);
        check("post_rst_launch", n_trmt, 7);
        done_pulse();
        cycles(2);
        check("post_rst_sent", n_sent, 6);
        check("post_rst_no_pend", n_trmt, 7);
        send_cmd(8'hC3, 8'h5A, 8'h0F);
        ack_cmd();
        check("clr_count_final", n_clr, 18);

        cycles(2);
        check("cmd_queue_empty", exp_cmd_q.size(), 0);
        check("tx_queue_empty", exp_tx_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
